alu_op_sequencer: RTL and testbench

- Initiator/driver for the team's 4-bit four-function combinational ALU (add, mul, xor, xnor; 2-bit select).
- Accepts queued operation commands over valid/ready, drives the ALU operand and select inputs from registers, and waits a programmable settle time.
- Captures the ALU result and returns it over a valid/ready response channel.
- Sits between a command producer (test controller / CPU shim) and the ALU.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_cmd_fifo.sv | 60 ++++++
 rtl/alu_op_sequencer.sv | 159 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants, FSM encoding and command record for the ALU operation sequencer.
// Defining ALU_SEQ_CHAIN_EN adds a per-command chain bit to the stored record.
package alu_seq_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 2;

    localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
    localparam logic [OP_W-1:0] OP_MUL  = 2'b01;
    localparam logic [OP_W-1:0] OP_XOR  = 2'b10;
    localparam logic [OP_W-1:0] OP_XNOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } seq_state_e;

    typedef struct packed {
`ifdef ALU_SEQ_CHAIN_EN
        logic              chain;
`endif
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count, full/empty flags and
// a synchronous active-high reset. The head entry is presented combinationally on rdata.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    // A push is refused while full even if a pop happens the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, drives the combinational ALU for SETTLE cycles and returns results.
// Optional ALU_SEQ_CHAIN_EN: cmd_chain port; chained commands take operand a from the last result.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_a,
    input  logic [3:0]  cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic        cmd_chain,
`endif
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic        alu_s0,
    output logic        alu_s1,
    input  logic [3:0]  alu_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_y,
    output logic [1:0]  rsp_op,
    output logic        busy
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    cmd_t push_cmd, head_cmd;
    logic fifo_full, fifo_empty, fifo_pop;

    seq_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [DATA_W-1:0] rsp_y_q, rsp_y_d, load_a;
    logic [OP_W-1:0]   op_q, op_d, rsp_op_q, rsp_op_d;
    logic              rsp_valid_q, rsp_valid_d, load;

    always_comb begin
        push_cmd    = '0;
        push_cmd.op = cmd_op;
        push_cmd.a  = cmd_a;
        push_cmd.b  = cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
        push_cmd.chain = cmd_chain;
`endif
    end

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (fifo_pop),
        .wdata (push_cmd),
        .rdata (head_cmd),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // rsp_y_q doubles as the accumulator source for chained commands.
    always_comb begin
`ifdef ALU_SEQ_CHAIN_EN
        load_a = head_cmd.chain ? rsp_y_q : head_cmd.a;
`else
        load_a = head_cmd.a;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_op_d    = rsp_op_q;
        fifo_pop    = 1'b0;
        load        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_y_d     = alu_y;
                    rsp_op_d    = op_q;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            fifo_pop = 1'b1;
            alu_a_d  = load_a;
            alu_b_d  = head_cmd.b;
            op_d     = head_cmd.op;
            cnt_d    = '0;
            state_d  = DRIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_op_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_op_q    <= rsp_op_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s0    = op_q[1];
    assign alu_s1    = op_q[0];
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_op    = rsp_op_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance with SETTLE=1 on an ideal ALU and
// one with SETTLE=3 on an ALU whose result lags its inputs by two cycles.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic logic [3:0] alu_f(input logic s0, input logic s1,
                                         input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = a * b;
        case ({s0, s1})
            2'b00:   alu_f = a + b;
            2'b01:   alu_f = p[3:0];
            2'b10:   alu_f = a ^ b;
            default: alu_f = ~(a ^ b);
        endcase
    endfunction

    // Instance 1: SETTLE=1, ideal combinational ALU
    logic       c1_valid, c1_ready, c1_chain;
    logic [1:0] c1_op;
    logic [3:0] c1_a, c1_b;
    logic [3:0] a1_a, a1_b, a1_y;
    logic       a1_s0, a1_s1;
    logic       r1_valid, r1_ready, busy1;
    logic [3:0] r1_y;
    logic [1:0] r1_op;

    assign a1_y = alu_f(a1_s0, a1_s1, a1_a, a1_b);

    alu_op_sequencer #(.DEPTH(4), .SETTLE(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (c1_valid),
        .cmd_ready (c1_ready),
        .cmd_op    (c1_op),
        .cmd_a     (c1_a),
        .cmd_b     (c1_b),
`ifdef ALU_SEQ_CHAIN_EN
        .cmd_chain (c1_chain),
`endif
        .alu_a     (a1_a),
        .alu_b     (a1_b),
        .alu_s0    (a1_s0),
        .alu_s1    (a1_s1),
        .alu_y     (a1_y),
        .rsp_valid (r1_valid),
        .rsp_ready (r1_ready),
        .rsp_y     (r1_y),
        .rsp_op    (r1_op),
        .busy      (busy1)
    );

    // Instance 3: SETTLE=3, ALU result two cycles behind its inputs
    logic       c3_valid, c3_ready, c3_chain;
    logic [1:0] c3_op;
    logic [3:0] c3_a, c3_b;
    logic [3:0] a3_a, a3_b;
    logic [3:0] a3_p1 = 4'h0;
    logic [3:0] a3_y  = 4'h0;
    logic       a3_s0, a3_s1;
    logic       r3_valid, r3_ready, busy3;
    logic [3:0] r3_y;
    logic [1:0] r3_op;

    always @(posedge clk) begin
        a3_p1 <= alu_f(a3_s0, a3_s1, a3_a, a3_b);
        a3_y  <= a3_p1;
    end

    alu_op_sequencer #(.DEPTH(4), .SETTLE(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (c3_valid),
        .cmd_ready (c3_ready),
        .cmd_op    (c3_op),
        .cmd_a     (c3_a),
        .cmd_b     (c3_b),
`ifdef ALU_SEQ_CHAIN_EN
        .cmd_chain (c3_chain),
`endif
        .alu_a     (a3_a),
        .alu_b     (a3_b),
        .alu_s0    (a3_s0),
        .alu_s1    (a3_s1),
        .alu_y     (a3_y),
        .rsp_valid (r3_valid),
        .rsp_ready (r3_ready),
        .rsp_y     (r3_y),
        .rsp_op    (r3_op),
        .busy      (busy3)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One command through an idle instance 1 with rsp_ready high; checks exact latency.
    task automatic run_one(input string nm, input logic [1:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] exp_a,
                           input logic [3:0] y, input logic chain);
        c1_op = op; c1_a = a; c1_b = b; c1_chain = chain; c1_valid = 1'b1; r1_ready = 1'b1;
        check({nm, " cmd_ready"}, c1_ready, 1);
        step();                               // edge N: push
        c1_valid = 1'b0;
        check({nm, " valid@N"}, r1_valid, 0);
        step();                               // edge N+1: operands loaded
        check({nm, " alu_a"}, a1_a, exp_a);
        check({nm, " alu_b"}, a1_b, b);
        check({nm, " alu_sel"}, {a1_s0, a1_s1}, op);
        check({nm, " valid@N+1"}, r1_valid, 0);
        check({nm, " busy"}, busy1, 1);
        step();                               // edge N+2: captured, consumed at N+3
        check({nm, " valid@N+2"}, r1_valid, 1);
        check({nm, " rsp_y"}, r1_y, y);
        check({nm, " rsp_op"}, r1_op, op);
        step();
        check({nm, " valid after ack"}, r1_valid, 0);
        check({nm, " idle"}, busy1, 0);
    endtask

    // Wait (bounded) for a response on instance 1, hold it under backpressure, then ack.
    task automatic expect1(input string nm, input logic [3:0] y, input logic [1:0] op,
                           input int hold);
        int n;
        n = 0;
        while (!r1_valid && n < 20) begin
            step();
            n++;
        end
        check({nm, " arrives"}, r1_valid, 1);
        for (int i = 0; i < hold; i++) begin
            check({nm, " held"}, {r1_valid, r1_op, r1_y}, {1'b1, op, y});
            step();
        end
        check({nm, " rsp_y"}, r1_y, y);
        check({nm, " rsp_op"}, r1_op, op);
        r1_ready = 1'b1;
        step();
        r1_ready = 1'b0;
    endtask

    typedef struct {
        string      nm;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
    } vec_t;

    vec_t vecs[6];
    int   accepted;
    int   seen;

    initial begin
        vecs[0] = '{"add 9+8",   2'b00, 4'h9, 4'h8, 4'h1};
        vecs[1] = '{"mul 7*3",   2'b01, 4'h7, 4'h3, 4'h5};
        vecs[2] = '{"xor A^6",   2'b10, 4'hA, 4'h6, 4'hC};
        vecs[3] = '{"xnor A,6",  2'b11, 4'hA, 4'h6, 4'h3};
        vecs[4] = '{"add F+1",   2'b00, 4'hF, 4'h1, 4'h0};
        vecs[5] = '{"mul F*F",   2'b01, 4'hF, 4'hF, 4'h1};

        rst = 1'b1;
        c1_valid = 0; c1_op = 0; c1_a = 0; c1_b = 0; c1_chain = 0; r1_ready = 0;
        c3_valid = 0; c3_op = 0; c3_a = 0; c3_b = 0; c3_chain = 0; r3_ready = 0;
        step();
        step();
        rst = 1'b0;

        check("reset cmd_ready", c1_ready, 1);
        check("reset alu", {a1_a, a1_b, a1_s0, a1_s1}, 0);
        check("reset rsp", {r1_valid, r1_y, r1_op}, 0);
        check("reset busy", busy1, 0);

        for (int i = 0; i < 6; i++) begin
            run_one(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].a, vecs[i].y, 1'b0);
        end

        // Back-to-back mul/xor/xnor, each response held 3 cycles under backpressure.
        r1_ready = 1'b0;
        c1_valid = 1'b1;
        c1_op = 2'b01; c1_a = 4'h7; c1_b = 4'h3;
        check("seq push mul", c1_ready, 1);
        step();
        c1_op = 2'b10; c1_a = 4'hA; c1_b = 4'h6;
        check("seq push xor", c1_ready, 1);
        step();
        c1_op = 2'b11; c1_a = 4'hA; c1_b = 4'h6;
        check("seq push xnor", c1_ready, 1);
        step();
        c1_valid = 1'b0;
        expect1("seq mul", 4'h5, 2'b01, 3);
        expect1("seq xor", 4'hC, 2'b10, 3);
        expect1("seq xnor", 4'h3, 2'b11, 3);
        step();
        check("seq drained", {r1_valid, busy1}, 0);

        // Fill: 6 push attempts with no consumer; 1 in flight + 4 queued.
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            c1_valid = 1'b1; c1_op = 2'b00; c1_a = 4'(i); c1_b = 4'(i);
            if (c1_ready) accepted++;
            step();
        end
        c1_valid = 1'b0;
        check("full accepted", accepted, 5);
        check("full cmd_ready", c1_ready, 0);
        for (int i = 0; i < 5; i++) begin
            expect1("full drain", 4'(2 * i), 2'b00, 0);
        end
        r1_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (r1_valid) seen++;
            step();
        end
        r1_ready = 1'b0;
        check("full no 6th", seen, 0);
        check("full idle", busy1, 0);

`ifdef ALU_SEQ_CHAIN_EN
        run_one("chain0", 2'b00, 4'h3, 4'h4, 4'h3, 4'h7, 1'b0);
        run_one("chain1", 2'b00, 4'h9, 4'h5, 4'h7, 4'hC, 1'b1);
`endif

        // SETTLE=3 with lagging ALU: latency N+4 and the fresh result is captured.
        r3_ready = 1'b1;
        c3_valid = 1'b1; c3_op = 2'b00; c3_a = 4'h2; c3_b = 4'h2;
        step();
        c3_valid = 1'b0;
        step(); step(); step();
        check("s3 add valid@N+3", r3_valid, 0);
        step();
        check("s3 add valid@N+4", r3_valid, 1);
        check("s3 add y", r3_y, 4'h4);
        step();
        c3_valid = 1'b1; c3_op = 2'b10; c3_a = 4'hF; c3_b = 4'h1;
        step();
        c3_valid = 1'b0;
        step(); step(); step();
        check("s3 xor valid@N+3", r3_valid, 0);
        step();
        check("s3 xor valid@N+4", r3_valid, 1);
        check("s3 xor y", r3_y, 4'hE);
        check("s3 xor op", r3_op, 2'b10);
        step();

        // Reset while in DRIVE with two commands queued.
        r3_ready = 1'b0;
        c3_valid = 1'b1; c3_op = 2'b01; c3_a = 4'h3; c3_b = 4'h3;
        step();
        c3_a = 4'h5;
        step();
        c3_a = 4'h6;
        step();
        c3_valid = 1'b0;
        check("rst pre busy", busy3, 1);
        check("rst pre alu_a", a3_a, 4'h3);
        check("rst pre valid", r3_valid, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst valid", r3_valid, 0);
        check("rst busy", busy3, 0);
        check("rst cmd_ready", c3_ready, 1);
        check("rst alu", {a3_a, a3_b, a3_s0, a3_s1}, 0);
        r3_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (r3_valid || busy3) seen++;
            step();
        end
        check("rst no stale", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
